// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: the PC-1 and PC-2 bit-selection tables,
// the 16-entry left-shift schedule, the key-schedule FSM state type, and small
// helpers for PC-1 and 28-bit rotation.
// Table entries use DES numbering: bit 1 is the most significant bit.
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied going into DES rounds 1..16 (index 0 = round 1).
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // PC-1: 64-bit key (parity bits included) to 56-bit C||D, C in the upper half.
  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return cd;
  endfunction

  // Rotations only ever move by 1 or 2 places.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int amt);
    return (amt == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int amt);
    return (amt == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational DES PC-2 permutation: 56-bit C||D in, 48-bit round subkey out.
// Ports:
//   cd_in      [55:0]  C half in [55:28], D half in [27:0]
//   subkey_out [47:0]  selected subkey, DES bit 1 at [47]
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_in,
  output logic [47:0] subkey_out
);

  // Pure bit selection; eight C||D bits are intentionally dropped by PC-2.
  always_comb begin
    subkey_out = '0;
    for (int i = 0; i < 48; i++) begin
      subkey_out[6'(47 - i)] = cd_in[6'(56 - PC2[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Generates the 16 DES round subkeys one at a time, in encrypt order K1..K16 or
// decrypt order K16..K1, advancing on each round_inc from the consumer.
// Optional feature macro: KEY_PARITY_CHECK_EN (per-byte odd-parity check of the
// loaded key; without it parity_err is tied to 0).
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   key_load     one-cycle pulse capturing key_in and decrypt
//   key_in[63:0] DES key, bit 63 = DES bit 1
//   decrypt      0 = encrypt order, 1 = decrypt order
//   round_inc    current subkey consumed, advance
//   subkey[47:0] current registered subkey
//   round_number issue-order index 0..15
//   key_valid    high only while the schedule is active
//   done         high after all 16 subkeys were consumed
//   parity_err   key parity error flag
// -----------------------------------------------------------------------------
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        round_inc,
  output logic [47:0] subkey,
  output logic [3:0]  round_number,
  output logic        key_valid,
  output logic        done,
  output logic        parity_err
);

  ks_state_e   state_q, state_nxt;
  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [55:0] cd_load;
  logic [47:0] subkey_q, subkey_nxt;
  logic [3:0]  round_q;
  logic [3:0]  enc_idx, dec_idx;
  logic        decrypt_q;
  logic        step;

  assign cd_load = pc1_perm(key_in);

  // key_load has priority, so a coincident round_inc is simply dropped.
  assign step = round_inc && (state_q == ACTIVE) && !key_load;

  // At issue index r, encrypt moves into DES round r+2 and decrypt backs out
  // of DES round 16-r; both index the 0-based shift table.
  assign enc_idx = round_q + 4'd1;
  assign dec_idx = 4'd15 - round_q;

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state_q;
    if (key_load)                      state_nxt = ACTIVE;
    else if (step && round_q == 4'd15) state_nxt = DONE;
  end

  // Next C/D. Encrypt pre-rotates on load so K1 is ready one cycle later;
  // decrypt loads C0/D0 unrotated, which equal C16/D16, giving K16 first.
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (key_load) begin
      if (decrypt) begin
        c_nxt = cd_load[55:28];
        d_nxt = cd_load[27:0];
      end else begin
        c_nxt = rotl28(cd_load[55:28], SHIFTS[0]);
        d_nxt = rotl28(cd_load[27:0], SHIFTS[0]);
      end
    end else if (step && round_q != 4'd15) begin
      if (decrypt_q) begin
        c_nxt = rotr28(c_q, SHIFTS[dec_idx]);
        d_nxt = rotr28(d_q, SHIFTS[dec_idx]);
      end else begin
        c_nxt = rotl28(c_q, SHIFTS[enc_idx]);
        d_nxt = rotl28(d_q, SHIFTS[enc_idx]);
      end
    end
  end

  des_pc2 u_pc2 (
    .cd_in      ({c_nxt, d_nxt}),
    .subkey_out (subkey_nxt)
  );

  // Datapath registers; subkey is registered from the next C/D so it lines
  // up with round_number on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_q       <= '0;
      d_q       <= '0;
      subkey_q  <= '0;
      round_q   <= '0;
      decrypt_q <= 1'b0;
    end else begin
      c_q <= c_nxt;
      d_q <= d_nxt;
      if (key_load || step) subkey_q <= subkey_nxt;
      if (key_load) begin
        round_q   <= '0;
        decrypt_q <= decrypt;
      end else if (step && round_q != 4'd15) begin
        round_q <= round_q + 4'd1;
      end
    end
  end

`ifdef KEY_PARITY_CHECK_EN
  logic parity_q;
  logic any_even;

  // DES keys carry odd parity per byte; an even byte flags an error.
  always_comb begin
    any_even = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^key_in[b*8 +: 8]) any_even = 1'b1;
    end
  end

  // Parity flag register, refreshed only on key_load
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        parity_q <= 1'b0;
    else if (key_load) parity_q <= any_even;
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign subkey       = subkey_q;
  assign round_number = round_q;
  assign key_valid    = (state_q == ACTIVE);
  assign done         = (state_q == DONE);

endmodule
